// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode type, packet constants and CRC4 helper for the mtm_alu input path
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  localparam int         PKT_BITS  = 11;
  localparam int         DATA_PKTS = 8;
  localparam logic       PKT_DATA  = 1'b0;
  localparam logic       PKT_CTRL  = 1'b1;
  localparam logic [3:0] CRC_POLY  = 4'h3;

  // x^4+x+1, init 0, message consumed MSB first
  function automatic logic [3:0] calc_crc4(input logic [67:0] d);
    logic [3:0] crc;
    crc = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      if (crc[3] ^ d[i]) crc = {crc[2:0], 1'b0} ^ CRC_POLY;
      else               crc = {crc[2:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/mtm_alu_rx_pkt.sv
// rtl/mtm_alu_rx_pkt.sv - 11-bit packet deserializer (start, type, 8 payload bits MSB first, stop)
module mtm_alu_rx_pkt
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       pkt_valid,
  output logic       pkt_type,
  output logic [7:0] pkt_byte,
  output logic       pkt_err
);

  typedef enum logic [2:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP, S_RESYNC} state_t;

  localparam logic [2:0] LAST_BIT = 3'(PKT_BITS - 4);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESYNC;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      pkt_valid <= 1'b0;
      pkt_type  <= 1'b0;
      pkt_byte  <= 8'h00;
      pkt_err   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      case (state)
        S_IDLE: if (!sin) state <= S_TYPE;
        S_TYPE: begin
          pkt_type <= sin;
          bit_cnt  <= 3'd0;
          state    <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          shift   <= {shift[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) state <= S_STOP;
        end
        S_STOP: begin
          if (sin) begin
            pkt_valid <= 1'b1;
            pkt_byte  <= shift;
            state     <= S_IDLE;
          end else begin
            pkt_err <= 1'b1;
            state   <= S_RESYNC;
          end
        end
        // wait for idle-high so we never lock onto the middle of a packet
        S_RESYNC: if (sin) state <= S_IDLE;
        default:  state <= S_RESYNC;
      endcase
    end
  end

endmodule

// File: rtl/mtm_alu_rx.sv
// rtl/mtm_alu_rx.sv - frame assembly and checking for the mtm_alu input path
// MTM_ALU_RX_CRC_CHECK_EN enables the CRC4 comparison; otherwise err_crc is tied low.
module mtm_alu_rx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op
);

  logic       pkt_valid;
  logic       pkt_type;
  logic [7:0] pkt_byte;
  logic       pkt_err;

  mtm_alu_rx_pkt u_pkt (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .pkt_valid (pkt_valid),
    .pkt_type  (pkt_type),
    .pkt_byte  (pkt_byte),
    .pkt_err   (pkt_err)
  );

  logic [63:0] data_sr;
  logic [3:0]  data_cnt;
  logic        data_overflow;
  logic [2:0]  rx_op;
  logic        fmt_bad;
  logic        crc_bad;
  logic        op_bad;

  assign rx_op   = pkt_byte[6:4];
  assign fmt_bad = (data_cnt != 4'(DATA_PKTS)) || data_overflow || pkt_byte[7];

`ifdef MTM_ALU_RX_CRC_CHECK_EN
  logic [3:0] rx_crc;
  assign rx_crc  = pkt_byte[3:0];
  assign crc_bad = (rx_crc != calc_crc4({data_sr, 1'b1, rx_op}));
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    op_bad = 1'b1;
    case (rx_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: op_bad = 1'b0;
      default:                       op_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sr       <= 64'h0;
      data_cnt      <= 4'd0;
      data_overflow <= 1'b0;
      out_valid     <= 1'b0;
      a             <= 32'h0;
      b             <= 32'h0;
      op            <= 3'b000;
      err_data      <= 1'b0;
      err_crc       <= 1'b0;
      err_op        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (pkt_err) begin
        out_valid     <= 1'b1;
        err_data      <= 1'b1;
        err_crc       <= 1'b0;
        err_op        <= 1'b0;
        data_cnt      <= 4'd0;
        data_overflow <= 1'b0;
      end else if (pkt_valid && pkt_type == PKT_CTRL) begin
        // one flag at most, data errors dominate CRC, CRC dominates opcode
        out_valid     <= 1'b1;
        err_data      <= fmt_bad;
        err_crc       <= !fmt_bad && crc_bad;
        err_op        <= !fmt_bad && !crc_bad && op_bad;
        b             <= data_sr[63:32];
        a             <= data_sr[31:0];
        op            <= rx_op;
        data_cnt      <= 4'd0;
        data_overflow <= 1'b0;
      end else if (pkt_valid && pkt_type == PKT_DATA) begin
        if (data_cnt < 4'(DATA_PKTS)) begin
          data_sr  <= {data_sr[55:0], pkt_byte};
          data_cnt <= data_cnt + 4'd1;
        end else begin
          data_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_rx.sv
// tb/tb_mtm_alu_rx.sv - self-checking bench for mtm_alu_rx (table vectors, corner sequences, random frames)
module tb_mtm_alu_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        out_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        err_data;
  logic        err_crc;
  logic        err_op;

  mtm_alu_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_valid (out_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .err_data  (err_data),
    .err_crc   (err_crc),
    .err_op    (err_op)
  );

  always #5 clk = ~clk;

`ifdef MTM_ALU_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int stop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ed;
    logic        ec;
    logic        eo;
    int          cyc;
  } res_t;

  res_t resq[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) resq.push_back('{a, b, op, err_data, err_crc, err_op, cyc});
  end

  typedef struct {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [3:0]  cx;
    int          n;
    logic        b7;
    logic [2:0]  exp_en;
    logic [2:0]  exp_dis;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // remainder of msg*x^4 divided by x^4+x+1
  function automatic logic [3:0] ref_crc(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'h0};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_errs(input int n, input logic b7, input logic [3:0] cx,
                                          input logic [2:0] o);
    if (n != 8 || b7) return 3'b100;
    if (CRC_EN && cx != 4'h0) return 3'b010;
    if (!(o inside {3'b000, 3'b001, 3'b100, 3'b101})) return 3'b001;
    return 3'b000;
  endfunction

  task automatic send_bit(input logic v);
    @(negedge clk);
    sin = v;
  endtask

  task automatic send_pkt(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    stop_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [31:0] fb, input logic [31:0] fa, input logic [2:0] o,
                            input logic [3:0] cx, input int n, input logic b7);
    logic [63:0] d;
    logic [7:0]  bv;
    logic [3:0]  c;
    d = {fb, fa};
    c = ref_crc({fb, fa, 1'b1, o}) ^ cx;
    for (int i = 0; i < n; i++) begin
      if (i < 8) bv = d[63-8*i -: 8];
      else       bv = 8'hA5;
      send_pkt(1'b0, bv, 1'b1);
    end
    send_pkt(1'b1, {b7, o, c}, 1'b1);
    idle(12);
  endtask

  task automatic check_result(input string name, input logic [2:0] exp_err, input logic [31:0] ea,
                              input logic [31:0] eb, input logic [2:0] eo);
    res_t r;
    check({name, " pulses"}, 64'(resq.size()), 64'd1);
    if (resq.size() > 0) begin
      r = resq.pop_front();
      check({name, " errs"}, {61'd0, r.ed, r.ec, r.eo}, {61'd0, exp_err});
      check({name, " latency"}, 64'(r.cyc), 64'(stop_cyc + 2));
      if (exp_err == 3'b000) begin
        check({name, " a"}, {32'd0, r.a}, {32'd0, ea});
        check({name, " b"}, {32'd0, r.b}, {32'd0, eb});
        check({name, " op"}, {61'd0, r.op}, {61'd0, eo});
      end
    end
    resq.delete();
  endtask

  initial begin
    vec_t        v;
    logic [31:0] rb;
    logic [31:0] ra;
    logic [2:0]  ro;
    logic [3:0]  rcx;
    int          rn;
    logic        rb7;

    vecs[0] = '{32'h3,          32'h5,          3'b100, 4'h0, 8, 1'b0, 3'b000, 3'b000};
    vecs[1] = '{32'h3,          32'h5,          3'b111, 4'h0, 8, 1'b0, 3'b001, 3'b001};
    vecs[2] = '{32'h3,          32'h5,          3'b100, 4'h1, 8, 1'b0, 3'b010, 3'b000};
    vecs[3] = '{32'h3,          32'h5,          3'b100, 4'h0, 7, 1'b0, 3'b100, 3'b100};
    vecs[4] = '{32'h3,          32'h5,          3'b100, 4'h0, 8, 1'b0, 3'b000, 3'b000};
    vecs[5] = '{32'hDEAD_BEEF,  32'h1234_5678,  3'b001, 4'h0, 8, 1'b0, 3'b000, 3'b000};
    vecs[6] = '{32'h0F0F_0F0F,  32'hF0F0_F0F0,  3'b000, 4'h0, 9, 1'b0, 3'b100, 3'b100};
    vecs[7] = '{32'h3,          32'h5,          3'b010, 4'h6, 8, 1'b0, 3'b010, 3'b001};
    vecs[8] = '{32'h3,          32'h5,          3'b100, 4'h0, 8, 1'b1, 3'b100, 3'b100};
    vecs[9] = '{32'hFFFF_FFFF,  32'h1,          3'b101, 4'h0, 8, 1'b0, 3'b000, 3'b000};

    repeat (3) @(negedge clk);
    check("reset out_valid/op/errs", {59'd0, out_valid, op, err_data, err_crc, err_op}, 64'd0);
    check("reset a", {32'd0, a}, 64'd0);
    check("reset b", {32'd0, b}, 64'd0);
    rst_n = 1'b1;
    idle(5);
    check("idle no pulse", 64'(resq.size()), 64'd0);

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      send_frame(v.b, v.a, v.op, v.cx, v.n, v.b7);
      check_result($sformatf("vec%0d", i), CRC_EN ? v.exp_en : v.exp_dis, v.a, v.b, v.op);
    end

    // stop bit of data packet 3 driven low, then line held idle
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    send_pkt(1'b0, 8'h33, 1'b0);
    idle(20);
    check_result("fmt err", 3'b100, 32'h0, 32'h0, 3'b000);
    send_frame(32'hFFFF_FFFF, 32'h1, 3'b101, 4'h0, 8, 1'b0);
    check_result("sub after fmt", 3'b000, 32'h1, 32'hFFFF_FFFF, 3'b101);

    // reset in the middle of packet 5, line held low across release
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'h5A, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sin = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst out_valid/op/errs", {59'd0, out_valid, op, err_data, err_crc, err_op}, 64'd0);
    check("midrst a", {32'd0, a}, 64'd0);
    check("midrst b", {32'd0, b}, 64'd0);
    rst_n = 1'b1;
    repeat (5) send_bit(1'b0);
    idle(15);
    check("midrst no pulse", 64'(resq.size()), 64'd0);
    resq.delete();
    send_frame(32'hA5A5_00FF, 32'h0F0F_1234, 3'b000, 4'h0, 8, 1'b0);
    check_result("and after rst", 3'b000, 32'h0F0F_1234, 32'hA5A5_00FF, 3'b000);

    for (int i = 0; i < 30; i++) begin
      rb  = $urandom;
      ra  = $urandom;
      ro  = 3'($urandom_range(0, 7));
      rcx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      rn  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 9)) : 8;
      rb7 = ($urandom_range(0, 15) == 0);
      send_frame(rb, ra, ro, rcx, rn, rb7);
      check_result($sformatf("rnd%0d", i), ref_errs(rn, rb7, rcx, ro), ra, rb, ro);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
